// File: rtl/log2_fixed_pkg.sv
// Shared types and helpers for the iterative base-2 logarithm unit.
package log2_fixed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the integer field; never below one bit so W=2 still has a field.
  function automatic int log2_iw(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/log2_fixed_if.sv
// Operand/result bus of log2_fixed: valid/ready on both the input and output side.
interface log2_fixed_if #(
  parameter int W         = 8,
  parameter int FRAC_BITS = 4
);
  localparam int IW = log2_fixed_pkg::log2_iw(W);

  // A transfer happens on a rising edge where valid & ready are both high;
  // the sender holds valid and its data unchanged until that edge.
  logic                    in_valid;
  logic                    in_ready;
  logic [W-1:0]            in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [IW+FRAC_BITS-1:0] out_result;
  logic                    out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_result, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_result, out_zero
  );
endinterface

// File: rtl/log2_fixed_msb_index.sv
// Combinational priority encoder: index of the highest set bit plus an all-zero flag.
module log2_fixed_msb_index #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  x_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (x_i[i]) idx_o = IW'(i);
    end
  end

  assign zero_o = ~|x_i;

endmodule

// File: rtl/log2_fixed.sv
// Sequential log2 of an unsigned integer: integer part from the MSB index,
// fraction one bit per cycle by repeated squaring of the normalised mantissa.
module log2_fixed
  import log2_fixed_pkg::*;
#(
  parameter int W         = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  log2_fixed_if.slave bus,
  output state_t    dbg_state_o
);

  localparam int IW = log2_iw(W);
  localparam int RW = IW + FRAC_BITS;
  localparam int CW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            zero_q;
  logic [RW-1:0]   res_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    m_q;

  logic [IW-1:0]   msb_idx;
  logic            msb_zero;
  logic [W:0]      sq_hi;
  logic [W-1:0]    m_d;
  logic            frac_bit_d;

  log2_fixed_msb_index #(.W(W), .IW(IW)) u_msb_index (
    .x_i    (bus.in_data),
    .idx_o  (msb_idx),
    .zero_o (msb_zero)
  );

  // Keep only bits [2W-1:W-1] of m*m; lower bits are truncated away.
  assign sq_hi      = (W+1)'(({{W{1'b0}}, m_q} * {{W{1'b0}}, m_q}) >> (W - 1));
  assign frac_bit_d = sq_hi[W];
  assign m_d        = frac_bit_d ? sq_hi[W:1] : sq_hi[W-1:0];

  // res_q starts as the integer part in the low bits; each fraction bit shifts
  // it left, so after FRAC_BITS steps it sits in the top IW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
      m_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            zero_q     <= msb_zero;
            if (msb_zero) begin
              res_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              res_q <= RW'(msb_idx);
              m_q   <= bus.in_data << (IW'(W - 1) - msb_idx);
              if (FRAC_BITS == 0) begin
                out_valid_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                cnt_q   <= CW'(FRAC_BITS - 1);
                state_q <= CALC;
              end
            end
          end
        end
        CALC: begin
          m_q   <= m_d;
          res_q <= (res_q << 1) | RW'(frac_bit_d);
          if (cnt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.out_zero   = zero_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_log2_fixed.sv
// Bench for log2_fixed: vector table, stall/reset sequences, a W=16 FRAC_BITS=0
// instance, and a shuffled sweep of every 8-bit operand against a reference model.
module tb_log2_fixed;
  import log2_fixed_pkg::*;

  localparam int W  = 8;
  localparam int F  = 4;
  localparam int RW = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  log2_fixed_if #(.W(8),  .FRAC_BITS(4)) bus8 ();
  log2_fixed_if #(.W(16), .FRAC_BITS(0)) bus16 ();
  state_t dbg8, dbg16;

  log2_fixed #(.W(8), .FRAC_BITS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave), .dbg_state_o(dbg8)
  );
  log2_fixed #(.W(16), .FRAC_BITS(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave), .dbg_state_o(dbg16)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [RW:0] exp_q[$];  // {zero, result}

  typedef struct {
    logic [W-1:0] x;
    logic [RW:0]  exp;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Reference: MSB index, then truncating squaring of a Q1.(W-1) mantissa.
  function automatic logic [RW:0] model(input logic [W-1:0] x);
    int k;
    longint m, s, lim;
    logic [F-1:0] fr;
    if (x == 0) return {1'b1, 7'd0};
    k = 0;
    for (int i = 0; i < W; i++) if (x[i]) k = i;
    m   = longint'(x) << (W - 1 - k);
    lim = longint'(1) << (2 * W - 1);
    fr  = '0;
    for (int j = 0; j < F; j++) begin
      s = m * m;
      if (s >= lim) begin
        fr = {fr[F-2:0], 1'b1};
        m  = s >> W;
      end else begin
        fr = {fr[F-2:0], 1'b0};
        m  = s >> (W - 1);
      end
    end
    return {1'b0, 3'(k), fr};
  endfunction

  // driver tasks
  task automatic send(input logic [W-1:0] x, input logic [RW:0] exp);
    int t;
    t = 0;
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.in_data  = x;
    while (!bus8.in_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", 32'(t < 30), 32'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_data  = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus8.out_valid && lat < 40);
  endtask

  task automatic retire(input string name);
    logic [RW:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, {bus8.out_zero, bus8.out_result}, e);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    logic [W-1:0] xs[256];
    logic [RW:0] held;
    int lat, seen, j;
    logic [W-1:0] tmp;

    vecs[0] = '{x: 8'd3,   exp: {1'b0, 7'b001_1001}, lat: 5};
    vecs[1] = '{x: 8'd255, exp: {1'b0, 7'b111_1111}, lat: 5};
    vecs[2] = '{x: 8'd8,   exp: {1'b0, 7'b011_0000}, lat: 5};
    vecs[3] = '{x: 8'd1,   exp: {1'b0, 7'b000_0000}, lat: 5};
    vecs[4] = '{x: 8'd0,   exp: {1'b1, 7'b000_0000}, lat: 1};
    vecs[5] = '{x: 8'd128, exp: {1'b0, 7'b111_0000}, lat: 5};
    vecs[6] = '{x: 8'd6,   exp: {1'b0, 7'b010_1001}, lat: 5};

    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;
    bus16.in_valid  = 1'b0;
    bus16.in_data   = '0;
    bus16.out_ready = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus8.in_ready),   32'd1);
    check("rst_out_valid", 32'(bus8.out_valid),  32'd0);
    check("rst_result",    32'(bus8.out_result), 32'd0);
    check("rst_zero",      32'(bus8.out_zero),   32'd0);
    check("rst_state",     32'(dbg8),            32'(IDLE));
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].x, vecs[i].exp);
      wait_valid(lat);
      check($sformatf("tbl_lat_x%0d", vecs[i].x), 32'(lat), 32'(vecs[i].lat));
      retire($sformatf("tbl_x%0d", vecs[i].x));
    end

    // downstream stall with a competing operand waiting upstream
    send(8'd3, {1'b0, 7'b001_1001});
    wait_valid(lat);
    check("stall_lat", 32'(lat), 32'd5);
    held = {bus8.out_zero, bus8.out_result};
    bus8.in_valid = 1'b1;
    bus8.in_data  = 8'd5;
    for (int h = 0; h < 6; h++) begin
      @(negedge clk);
      check("stall_valid",    32'(bus8.out_valid), 32'd1);
      check("stall_result",   32'({bus8.out_zero, bus8.out_result}), 32'(held));
      check("stall_in_ready", 32'(bus8.in_ready),  32'd0);
    end
    retire("stall_x3");
    @(negedge clk);
    check("post_retire_valid", 32'(bus8.out_valid), 32'd0);
    check("post_retire_ready", 32'(bus8.in_ready),  32'd1);
    check("post_retire_state", 32'(dbg8),           32'(IDLE));
    @(posedge clk);
    exp_q.push_back(model(8'd5));
    #1;
    bus8.in_valid = 1'b0;
    wait_valid(lat);
    check("queued_lat", 32'(lat), 32'd5);
    retire("queued_x5");

    // reset in the middle of a calculation
    send(8'd200, model(8'd200));
    repeat (2) @(negedge clk);
    check("abort_in_calc", 32'(dbg8), 32'(CALC));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(bus8.in_ready),   32'd1);
    check("abort_out_valid", 32'(bus8.out_valid),  32'd0);
    check("abort_result",    32'(bus8.out_result), 32'd0);
    check("abort_zero",      32'(bus8.out_zero),   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    send(8'd16, {1'b0, 7'b100_0000});
    wait_valid(lat);
    check("after_abort_lat", 32'(lat), 32'd5);
    retire("after_abort_x16");

    // W=16, FRAC_BITS=0 instance
    @(negedge clk);
    bus16.in_valid = 1'b1;
    bus16.in_data  = 16'd40000;
    check("w16_in_ready", 32'(bus16.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus16.out_valid && lat < 40);
    check("w16_lat",    32'(lat),              32'd1);
    check("w16_result", 32'(bus16.out_result), 32'd15);
    check("w16_zero",   32'(bus16.out_zero),   32'd0);
    bus16.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus16.out_ready = 1'b0;

    // shuffled sweep of every operand with random downstream back-pressure
    for (int i = 0; i < 256; i++) xs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = xs[i];
      xs[i] = xs[j];
      xs[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      send(xs[i], model(xs[i]));
      wait_valid(lat);
      check($sformatf("sweep_lat_x%0d", xs[i]), 32'(lat), (xs[i] == 0) ? 32'd1 : 32'd5);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      retire($sformatf("sweep_x%0d", xs[i]));
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
